// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction FIFO.
package branch_resolver_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } resolver_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing signals of the branch resolver; master drives, slave is the resolver.
interface branch_resolver_if;

  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        res_orphan;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_taken, res_target,
    input  pred_ready, redirect, redirect_pc, flush, res_orphan
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_taken, res_target,
    output pred_ready, redirect, redirect_pc, flush, res_orphan
  );

endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// DEPTH-entry FIFO of outstanding predictions; wrap-bit pointers, head is read combinationally.
module pred_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  pred_rec_t wdata,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [AW:0]   head_ptr;
  logic [AW:0]   tail_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (head_ptr == tail_ptr);
  assign full    = (head_ptr[AW-1:0] == tail_ptr[AW-1:0]) && (head_ptr[AW] != tail_ptr[AW]);
  assign head    = mem[head_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (do_pop)  head_ptr <= head_ptr + (AW+1)'(1);
      if (do_push) tail_ptr <= tail_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[tail_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares fetch predictions against execute outcomes, redirects and flushes on mispredict.
// Optional BRANCH_STATS_EN adds resolve_count / mispredict_count outputs.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolver_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        resolve_count,
  output logic [31:0]        mispredict_count
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  resolver_state_e state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  pred_rec_t   head;
  pred_rec_t   wdata;
  logic        full;
  logic        empty;
  logic        res_fire;
  logic        orphan;
  logic        wrong;
  logic        mispredict;
  logic        pop;
  logic        push;
  logic [31:0] actual_next;

  assign wdata    = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
  assign res_fire = (state == RUN) && bus.res_valid;

  // With an empty FIFO the head is stale, but orphan already forces a mispredict.
  assign orphan      = empty || (head.pc != bus.res_pc);
  assign wrong       = orphan || (head.taken != bus.res_taken) ||
                       (bus.res_taken && (head.target != bus.res_target));
  assign actual_next = bus.res_taken ? bus.res_target : bus.res_pc + INSTR_BYTES;
  assign mispredict  = res_fire && wrong;
  assign pop         = res_fire && !wrong;

  // Gated by rst_n so fetch sees no acceptance while reset is held.
  assign bus.pred_ready = rst_n && (state == RUN) && !full;
  assign push           = bus.pred_valid && bus.pred_ready && !mispredict;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      RUN: begin
        if (mispredict) begin
          state_next = FLUSH;
          cnt_next   = CW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
      bus.flush       <= 1'b0;
      bus.res_orphan  <= 1'b0;
    end else begin
      bus.redirect   <= mispredict;
      bus.res_orphan <= mispredict && orphan;
      bus.flush      <= (state_next == FLUSH);
      if (mispredict) bus.redirect_pc <= actual_next;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_count    <= '0;
      mispredict_count <= '0;
    end else begin
      if (res_fire)   resolve_count    <= resolve_count + 32'd1;
      if (mispredict) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule
